// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the uart_tx arbiter slice
//
// Holds the FSM state encoding, the default requester count and the
// grant-index width helper used by uart_rr_arb and uart_tx_arb.
// Optional feature macro (used by uart_tx_arb): UART_TX_ARB_TIMEOUT_EN.
package uart_pkg;

  localparam int NREQ_DEF = 4;

  // Grant index width; never narrower than one bit.
  function automatic int gid_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int GID_W_DEF = gid_w(NREQ_DEF);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

endpackage

// File: rtl/uart_rr_arb.sv
// rtl/uart_rr_arb.sv - round-robin requester selection with rotating pointer
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset (ptr -> 0)
//   req_valid  in   NREQ pending flags
//   grant_en   in   commit the current selection and advance ptr
//   any_valid  out  at least one requester pending
//   grant_idx  out  first pending index found scanning from ptr, wrapping
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic                     grant_en,
  output logic                     any_valid,
  output logic [gid_w(NREQ)-1:0]   grant_idx
);

  localparam int GW = gid_w(NREQ);

  logic [GW-1:0] ptr;
  logic [GW:0]   cand;

  // One extra bit on cand lets ptr+k exceed NREQ-1 before the wrap.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (GW+1)'(k);
      if (cand >= (GW+1)'(NREQ)) begin
        cand = cand - (GW+1)'(NREQ);
      end
      if (!any_valid && req_valid[cand[GW-1:0]]) begin
        any_valid = 1'b1;
        grant_idx = cand[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (grant_en && any_valid) begin
      ptr <= (grant_idx == GW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - shares one uart_tx between NREQ byte requesters
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   req_valid    in   NREQ  byte-pending flags, held with data until accepted
//   req_data     in   8*NREQ bytes, requester i at [8i+7:8i]
//   req_ready    out  NREQ  one-cycle accept pulse (LOAD state)
//   tx_start     out  start strobe to uart_tx (START state)
//   tx_din       out  8     byte to uart_tx, held until the next LOAD
//   tx_done      in   frame complete, only honoured in WAIT
//   grant_id     out  index of the requester owning the transmitter
//   busy         out  high whenever the FSM is not IDLE
//   timeout_err  out  sticky WAIT watchdog flag
// Macro UART_TX_ARB_TIMEOUT_EN adds the WAIT watchdog; otherwise
// timeout_err is tied low and WAIT exits only on tx_done.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_din,
  input  logic                     tx_done,
  output logic [gid_w(NREQ)-1:0]   grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int GW = gid_w(NREQ);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          any_valid;
  logic [GW-1:0] sel;
  logic          timeout_hit;

  uart_rr_arb #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant_en  (state == S_IDLE),
    .any_valid (any_valid),
    .grant_idx (sel)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_valid) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (tx_done || timeout_hit) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The grant is fixed in IDLE; the byte is taken at the end of LOAD so the
  // requester's data is sampled on the same edge its ready pulse completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      grant_id <= '0;
      tx_din   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_valid) begin
        grant_id <= sel;
      end
      if (state == S_LOAD) begin
        tx_din <= req_data[int'(grant_id)*8 +: 8];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_LOAD) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign tx_start = (state == S_START);
  assign busy     = (state != S_IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wd_cnt;
  logic          wd_err;

  // Counter is zeroed on the START->WAIT edge, so WAIT cycle k sees k-1.
  assign timeout_hit = (state == S_WAIT) && !tx_done &&
                       (wd_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (state == S_START) begin
        wd_cnt <= '0;
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (timeout_hit) begin
        wd_err <= 1'b1;
      end
    end
  end

  assign timeout_err = wd_err;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - randomized self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_din;
  logic              tx_done;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  int         checks = 0;
  int         errors = 0;
  int         mptr = 0;
  logic [7:0] last_byte = 8'h00;

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(NREQ), .TIMEOUT_CYC(50)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_din      (tx_din),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called from an IDLE sample with requester e pending; walks one full frame.
  task automatic serve(input int e, input logic [7:0] b, input int d, input bit gap_done);
    int n;
    bit stable;
    tick;
    n = 1;
    while (req_ready == '0 && n < 20) begin
      tick;
      n++;
    end
    check("ready_lat", n, 1);
    check("req_ready", req_ready, 32'd1 << e);
    check("grant_id", grant_id, e);
    check("busy_load", busy, 1);
    check("start_in_load", tx_start, 0);
    tick;
    check("tx_start", tx_start, 1);
    check("tx_din", tx_din, b);
    check("ready_1cyc", req_ready, 0);
    req_valid[e] = 1'b0;
    req_data[8*e +: 8] = 8'($urandom);
    mptr = (e + 1) % NREQ;
    last_byte = b;
    tick;
    check("start_1cyc", tx_start, 0);
    stable = 1'b1;
    repeat (d) begin
      if (tx_din !== b || grant_id !== 2'(e) || busy !== 1'b1 || tx_start !== 1'b0)
        stable = 1'b0;
      tick;
    end
    check("wait_hold", stable, 1);
    tx_done = 1'b1;
    tick;
    check("gap_busy", busy, 1);
    check("gap_start", tx_start, 0);
    tx_done = gap_done;
    tick;
    tx_done = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_din", tx_din, b);
  endtask

  // Reference: with the pending set frozen, grants come out in ascending
  // index order rotated to start at the model pointer.
  task automatic run_round(input logic [NREQ-1:0] mask, input int dlo, input int dhi);
    logic [7:0] bytes [NREQ];
    int order [$];
    for (int i = 0; i < NREQ; i++) begin
      bytes[i] = 8'($urandom);
      if (mask[i]) req_data[8*i +: 8] = bytes[i];
    end
    req_valid = mask;
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(mptr + k) % NREQ]) order.push_back((mptr + k) % NREQ);
    end
    foreach (order[j]) begin
      serve(order[j], bytes[order[j]], int'($urandom_range(dhi, dlo)), 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog bench did not finish");
    $fatal(1);
  end

  initial begin
    bit quiet;
    int n;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    rst       = 1'b0;
    repeat (2) tick;
    req_valid = 4'b1111;
    tick;
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_start", tx_start, 0);
    check("rst_din", tx_din, 0);
    check("rst_gid", grant_id, 0);
    check("rst_toerr", timeout_err, 0);
    req_valid = '0;
    rst = 1'b1;
    tick;

    run_round(4'b1111, 9, 9);
    run_round(4'b1111, 9, 9);
    run_round(4'b0100, 0, 3);
    run_round(4'b1001, 0, 3);

    // Spurious done in IDLE
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    check("spur_busy", busy, 0);
    check("spur_din", tx_din, last_byte);
    check("spur_ready", req_ready, 0);

    // Reset while in WAIT
    req_data[7:0] = 8'h3C;
    req_valid = 4'b0001;
    tick;
    check("mw_ready", req_ready, 1);
    tick;
    check("mw_start", tx_start, 1);
    req_valid = '0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("mw_busy", busy, 0);
    check("mw_start_rst", tx_start, 0);
    check("mw_din", tx_din, 0);
    check("mw_gid", grant_id, 0);
    check("mw_ready_rst", req_ready, 0);
    tick;
    tick;
    rst = 1'b1;
    mptr = 0;
    last_byte = 8'h00;
    quiet = 1'b1;
    repeat (10) begin
      tick;
      if (tx_start !== 1'b0 || req_ready !== '0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("mw_quiet", quiet, 1);

    for (int r = 0; r < 30; r++) begin
      run_round(4'($urandom_range(15, 1)), 0, 12);
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    req_data[15:8] = 8'h5A;
    req_valid = 4'b0010;
    tick;
    check("to_ready", req_ready, 2);
    tick;
    check("to_start", tx_start, 1);
    req_valid = '0;
    n = 0;
    while (timeout_err !== 1'b1 && n < 80) begin
      tick;
      n++;
    end
    check("to_cycles", n, 51);
    check("to_gap_busy", busy, 1);
    tick;
    check("to_idle_busy", busy, 0);
    mptr = 2;
    run_round(4'b0011, 0, 5);
    check("to_sticky", timeout_err, 1);
`else
    n = 0;
    check("toerr_off", timeout_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
